adat_deframer: RTL and testbench

ADAT optical-line receiver. It is the stage directly downstream of the ADAT framer.
- Takes the NRZI `adat` line, oversampled by `mclk`, and recovers bit timing.
- Finds the 10-zero sync run and strips the separator '1' bits.
- Rebuilds the eight 24-bit channel words and the 4 user bits, then publishes them atomically once per frame.
- Gives the loopback/receive path the exact inverse of the framer's bit map.

---
 rtl/adat_deframer.sv | 120 ++++++++++++
 tb/tb_adat_deframer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/adat_deframer.sv
// adat_deframer: ADAT NRZI receiver; recovers eight 24-bit channels plus user bits and publishes them once per frame.
// Define ADAT_DEFRAMER_ERRCNT_EN to build the saturating violation counter behind err_count.
module adat_deframer #(
   parameter int OVERSAMPLE = 4,
   parameter int SYNC_ZEROS = 10
) (
   input  logic        mclk,
   input  logic        rst,
   input  logic        adat,
   output logic [23:0] chan1,
   output logic [23:0] chan2,
   output logic [23:0] chan3,
   output logic [23:0] chan4,
   output logic [23:0] chan5,
   output logic [23:0] chan6,
   output logic [23:0] chan7,
   output logic [23:0] chan8,
   output logic [3:0]  user,
   output logic        frame_valid,
   output logic        locked,
   output logic        err,
   output logic [15:0] err_count
);
   localparam int PW = $clog2(OVERSAMPLE);
   typedef enum logic {HUNT, LOCKED} state_t;
   state_t state;
   logic s1, sync_q, hist_q, edge_seen;
   logic [PW-1:0] ph;
   logic [3:0] zcnt;
   logic [7:0] p;
   logic [191:0] shd;
   logic [3:0] ush;
   logic edge_det, strb, sep, zero_pos, bad;
   logic [7:0] np;
   assign edge_det = sync_q ^ hist_q;
   assign strb = !edge_det && ph == PW'(OVERSAMPLE / 2);
   assign np = p + 8'd1;
   assign sep = (np <= 8'hF0 && np % 8'd5 == 8'd0) || np == 8'hFB;
   assign zero_pos = np >= 8'hF1 && np <= 8'hFA;
   assign bad = sep ? !edge_seen : zero_pos && edge_seen;
   // Data bits arrive chan1[0] first, so a right shift leaves chan1 in the low 24 bits at frame end.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
         edge_seen <= 1'b0;
         ph <= '0;
         state <= HUNT;
         zcnt <= '0;
         p <= '0;
         shd <= '0;
         ush <= '0;
         chan1 <= '0;
         chan2 <= '0;
         chan3 <= '0;
         chan4 <= '0;
         chan5 <= '0;
         chan6 <= '0;
         chan7 <= '0;
         chan8 <= '0;
         user <= '0;
         frame_valid <= 1'b0;
         locked <= 1'b0;
         err <= 1'b0;
      end else begin
         s1 <= adat;
         sync_q <= s1;
         hist_q <= sync_q;
         err <= 1'b0;
         frame_valid <= 1'b0;
         if (edge_det) begin
            ph <= PW'(1);
            edge_seen <= 1'b1;
         end else begin
            ph <= ph == PW'(OVERSAMPLE - 1) ? '0 : ph + PW'(1);
            if (strb) edge_seen <= 1'b0;
         end
         if (strb) begin
            if (state == HUNT) begin
               zcnt <= edge_seen ? 4'd0 : zcnt == 4'hF ? zcnt : zcnt + 4'd1;
               if (edge_seen && zcnt >= 4'(SYNC_ZEROS)) begin
                  state <= LOCKED;
                  p <= 8'hFB;
                  locked <= 1'b1;
               end
            end else if (bad) begin
               state <= HUNT;
               zcnt <= '0;
               locked <= 1'b0;
               err <= 1'b1;
            end else begin
               p <= np;
               if (np >= 8'hFC) ush <= {edge_seen, ush[3:1]};
               else if (!sep && !zero_pos) shd <= {edge_seen, shd[191:1]};
               if (np == 8'hF0) begin
                  chan1 <= shd[23:0];
                  chan2 <= shd[47:24];
                  chan3 <= shd[71:48];
                  chan4 <= shd[95:72];
                  chan5 <= shd[119:96];
                  chan6 <= shd[143:120];
                  chan7 <= shd[167:144];
                  chan8 <= shd[191:168];
                  user <= ush;
                  frame_valid <= 1'b1;
               end
            end
         end
      end
   end
`ifdef ADAT_DEFRAMER_ERRCNT_EN
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) err_count <= '0;
      else if (err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
   end
`else
   assign err_count = 16'd0;
`endif
endmodule

// File: tb/tb_adat_deframer.sv
// tb_adat_deframer: framer-model stimulus with random channel data; a scoreboard checks every publish.
module tb_adat_deframer;
   logic mclk = 1'b0, rst = 1'b1, adat = 1'b0;
   logic [23:0] chan1, chan2, chan3, chan4, chan5, chan6, chan7, chan8;
   logic [3:0] user;
   logic frame_valid, locked, err;
   logic [15:0] err_count;
   logic [191:0] dut_ch;
   int checks = 0, errors = 0;
   typedef struct packed {
      logic [191:0] ch;
      logic [3:0]   u;
      int           idx;
   } rec_t;
   rec_t q[$];
   logic [195:0] last_pub = '0;
   logic lvl = 1'b0, prev_ok = 1'b0;
   int err_seen = 0, exp_err = 0, exp_cnt = 0;
   int cyc = 0, prev_idx = -10, prev_cyc = 0;
   int kinds[15] = '{0, 0, 0, 2, 2, 2, 2, 2, 1, 1, 1, 2, 2, 2, 2};
   int fposs[15] = '{-1, -1, -1, -1, -1, 'h55, -1, -1, -1, 'h55, -1, -1, -1, 'h0A, -1};
   int sposs[15] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 'h20, -1, -1, -1};
   int rposs[15] = '{-1, -1, -1, -1, -1, -1, -1, 'h80, -1, -1, -1, -1, -1, -1, -1};

   adat_deframer dut (
      .mclk(mclk), .rst(rst), .adat(adat),
      .chan1(chan1), .chan2(chan2), .chan3(chan3), .chan4(chan4),
      .chan5(chan5), .chan6(chan6), .chan7(chan7), .chan8(chan8),
      .user(user), .frame_valid(frame_valid), .locked(locked),
      .err(err), .err_count(err_count)
   );

   always #5 mclk = ~mclk;
   assign dut_ch = {chan8, chan7, chan6, chan5, chan4, chan3, chan2, chan1};

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Framer bit map: separators, LSB-first channel nibbles, sync zeros, user bits.
   function automatic logic fbit(input int p, input logic [191:0] ch, input logic [3:0] u);
      if (p <= 'hF0) return (p % 5 == 0) ? 1'b1 : ch[(p / 30) * 24 + ((p % 30) / 5) * 4 + (p % 5) - 1];
      if (p <= 'hFA) return 1'b0;
      if (p == 'hFB) return 1'b1;
      return u[p - 'hFC];
   endfunction

   task automatic send_bit(input logic b);
      @(negedge mclk);
      if (b) lvl = ~lvl;
      adat = lvl;
      repeat (3) @(negedge mclk);
   endtask

   // One unit = user bits at 0xFC..0xFF followed by positions 0x00..0xFB.
   task automatic send_unit(input int idx, input int kind, input int fpos, input int spos, input int rpos);
      logic [191:0] ch;
      logic [3:0] u;
      logic disrupted, skip, b;
      int p;
      disrupted = 1'b0;
      skip = 1'b0;
      ch = kind == 0 ? {24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'h123456, 24'hABCDEF}
         : kind == 1 ? 192'd0
         : {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      u = kind == 0 ? 4'hA : kind == 1 ? 4'h0 : 4'($urandom());
      if (fpos >= 0 || spos >= 0) begin
         exp_err++;
         exp_cnt++;
      end
      for (int i = 0; i < 256; i++) begin
         p = (i + 'hFC) % 256;
         if (p == spos) begin
            repeat (600) @(negedge mclk);
            disrupted = 1'b1;
            skip = 1'b1;
         end
         if (p == 'hF1) skip = 1'b0;
         if (!skip) begin
            if (p == rpos) begin
               #1 rst = 1'b1;
               #1 chk("reset_mid_outputs", 256'({dut_ch, user, frame_valid, locked, err, err_count}), 256'(0));
               last_pub = '0;
               exp_cnt = 0;
               disrupted = 1'b1;
            end
            if (rpos >= 0 && p == rpos + 2) #1 rst = 1'b0;
            b = fbit(p, ch, u);
            if (p == fpos) begin
               b = 1'b0;
               disrupted = 1'b1;
            end
            if (p == 'hF0 && prev_ok && !disrupted) begin
               q.push_back('{ch: ch, u: u, idx: idx});
               last_pub = {ch, u};
            end
            send_bit(b);
            if (p == 'hF2) begin
               chk($sformatf("locked_u%0d", idx), 256'(locked), 256'(prev_ok && !disrupted));
               if (disrupted) chk($sformatf("held_outputs_u%0d", idx), 256'({dut_ch, user}), 256'(last_pub));
            end
         end
      end
      prev_ok = 1'b1;
   endtask

   always @(negedge mclk) begin
      rec_t r;
      cyc++;
      if (err) err_seen++;
      if (frame_valid) begin
         if (q.size() == 0) chk("unexpected_publish", 256'(q.size()), 256'(1));
         else begin
            r = q.pop_front();
            for (int c = 0; c < 8; c++)
               chk($sformatf("chan%0d_u%0d", c + 1, r.idx), 256'(dut_ch[c * 24 +: 24]), 256'(r.ch[c * 24 +: 24]));
            chk($sformatf("user_u%0d", r.idx), 256'(user), 256'(r.u));
            if (r.idx == prev_idx + 1) chk("publish_spacing", 256'(cyc - prev_cyc), 256'(1024));
            prev_idx = r.idx;
            prev_cyc = cyc;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge mclk);
      #1 chk("reset_state", 256'({dut_ch, user, frame_valid, locked, err, err_count}), 256'(0));
      rst = 1'b0;
      repeat (3) send_bit(1'b0);
      for (int k = 0; k < 15; k++) send_unit(k, kinds[k], fposs[k], sposs[k], rposs[k]);
      repeat (4) @(negedge mclk);
      chk("missing_publish", 256'(q.size()), 256'(0));
      chk("err_pulses", 256'(err_seen), 256'(exp_err));
`ifdef ADAT_DEFRAMER_ERRCNT_EN
      chk("err_count", 256'(err_count), 256'(exp_cnt));
`else
      chk("err_count", 256'(err_count), 256'(0));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
